conv_window_gen: RTL

Parametrised streaming K x K sliding-window generator for the convolution layers. It takes a raster-order pixel stream with CH packed channels per pixel and emits flattened K x K x CH windows. Supports configurable stride and a start-of-frame resync. It has a valid/ready handshake on both sides, so the downstream MAC array can stall it. It replaces the fixed 5x5, single-channel, valid-only window generator in front of every conv stage.

---
 rtl/conv_window_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// ============================================================================
// Module   : conv_window_gen
// Purpose  : Streaming K x K x CH sliding-window generator with stride, sof
//            resync and valid/ready on both sides.
// Options  : CONV_WIN_FRAME_CHECK_EN adds a sticky frame_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int CH     = 1,
    parameter int DATA_W = 8,
    parameter int STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    output logic                         in_ready,
    input  logic                         sof,
    input  logic [CH*DATA_W-1:0]         din,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [K*K*CH*DATA_W-1:0]     win,
    output logic [9:0]                   win_x,
    output logic [9:0]                   win_y,
    output logic                         frame_done
`ifdef CONV_WIN_FRAME_CHECK_EN
    ,
    output logic                         frame_err
`endif
);

    localparam int              PW      = CH * DATA_W;
    localparam int              PHW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [9:0]      X_LAST  = 10'(IMG_W - 1);
    localparam logic [9:0]      Y_LAST  = 10'(IMG_H - 1);
    localparam logic [9:0]      K_LAST  = 10'(K - 1);
    localparam logic [PHW-1:0]  PH_LAST = PHW'(STRIDE - 1);

    logic [PW-1:0]  line_buf [K-1][IMG_W];
    logic [PW-1:0]  lb_in    [K-1];
    logic [PW-1:0]  lb_out   [K-1];
    logic [PW-1:0]  row_in   [K];
    logic [PW-1:0]  win_reg  [K][K];

    logic [9:0]     x, y, cur_x, cur_y, nx, ny;
    logic [PHW-1:0] px, py, px_eff, py_eff, px_nxt, py_step, py_nxt;
    logic           accept, end_row, last_pix, complete;

    assign in_ready = !win_valid || win_ready;
    assign accept   = valid_in && in_ready;

    // Line buffer j delays by (K-1-j) rows; it feeds window row j.
    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_out[j] = line_buf[j][0];
        end
        lb_in[K-2] = din;
        for (int j = 0; j < K - 2; j++) begin
            lb_in[j] = lb_out[j+1];
        end
        row_in[K-1] = din;
        for (int r = 0; r < K - 1; r++) begin
            row_in[r] = lb_out[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int i = 0; i < IMG_W - 1; i++) begin
                    line_buf[j][i] <= line_buf[j][i+1];
                end
                line_buf[j][IMG_W-1] <= lb_in[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_reg[r][c] <= win_reg[r][c+1];
                end
                win_reg[r][K-1] <= row_in[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign win[(r*K+c)*PW +: PW] = win_reg[r][c];
        end
    end

    // Phases are forced to 0 at the first full-kernel column/row so no divider is needed.
    always_comb begin
        cur_x    = sof ? 10'd0 : x;
        cur_y    = sof ? 10'd0 : y;
        end_row  = (cur_x == X_LAST);
        last_pix = end_row && (cur_y == Y_LAST);
        nx       = end_row ? 10'd0 : cur_x + 10'd1;
        ny       = end_row ? ((cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1) : cur_y;
        px_eff   = (cur_x == K_LAST) ? '0 : px;
        py_eff   = (cur_y == K_LAST) ? '0 : py;
        px_nxt   = (px_eff == PH_LAST) ? '0 : px_eff + PHW'(1);
        py_step  = (py_eff == PH_LAST) ? '0 : py_eff + PHW'(1);
        py_nxt   = end_row ? py_step : py_eff;
        complete = (cur_x >= K_LAST) && (cur_y >= K_LAST) && (px_eff == '0) && (py_eff == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            px         <= '0;
            py         <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            x          <= nx;
            y          <= ny;
            px         <= px_nxt;
            py         <= py_nxt;
            win_valid  <= complete;
            win_x      <= cur_x;
            win_y      <= cur_y;
            frame_done <= last_pix;
        end else if (win_ready) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

`ifdef CONV_WIN_FRAME_CHECK_EN
    logic first_pix, sof_mode;

    // A frame start without sof is an error for the first pixel, or once sof framing is in use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            first_pix <= 1'b1;
            sof_mode  <= 1'b0;
        end else if (accept) begin
            first_pix <= 1'b0;
            if (sof) begin
                sof_mode <= 1'b1;
            end
            if (sof && (x != 10'd0 || y != 10'd0)) begin
                frame_err <= 1'b1;
            end
            if (!sof && x == 10'd0 && y == 10'd0 && (first_pix || sof_mode)) begin
                frame_err <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
